// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle MIPS controller (master)
// and the datapath / shared-memory side (slave).
interface mips_multicycle_ctrl_if #(
    parameter int PERF_W = 32
);
    logic [5:0]        opcode;
    logic              alu_zero;
    logic              mem_ready;
    logic              mem_req;
    logic              mem_we;
    logic              mem_addr_sel;
    logic              ir_write;
    logic              pc_write;
    logic              pc_src;
    logic [1:0]        alu_src_b;
    logic              reg_write;
    logic [1:0]        wb_sel;
    logic              illegal_op;
    logic              bus_error;
    logic              halted;
    logic [PERF_W-1:0] instr_retired;

    modport master (
        input  opcode, alu_zero, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               alu_src_b, reg_write, wb_sel, illegal_op, bus_error, halted,
               instr_retired
    );

    modport slave (
        output opcode, alu_zero, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               alu_src_b, reg_write, wb_sel, illegal_op, bus_error, halted,
               instr_retired
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer with memory wait-state timeout.
// Optional retired-instruction counter enabled by MIPS_CTRL_PERF_EN.
module mips_multicycle_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int PERF_W   = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_ALU  = 6'b000001;
    localparam logic [5:0] OP_LI   = 6'b100100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       bus_error_q;
    logic       retire, timeout, wait_hit;

    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
    logic [1:0] alu_src_b, wb_sel;
    logic       reg_write, illegal_op, halted;

    assign wait_hit = (wait_q == 8'(MAX_WAIT));

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alu_src_b    = 2'b00;
        reg_write    = 1'b0;
        wb_sel       = 2'b00;
        illegal_op   = 1'b0;
        halted       = 1'b0;
        retire       = 1'b0;
        timeout      = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                // A ready arriving on the timeout cycle still completes normally.
                if (bus.mem_ready) begin
                    mem_req   = 1'b1;
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                    state_d   = S_DECODE;
                end else if (wait_hit) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end else begin
                    mem_req = 1'b1;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_ALU, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
                    OP_LI:   state_d = S_WB;
                    OP_HALT: begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                case (bus.opcode)
                    OP_ALU: state_d = S_WB;
                    OP_LW, OP_SW: begin
                        alu_src_b = 2'b10;
                        state_d   = S_MEM;
                    end
                    OP_BEQ: begin
                        pc_write = bus.alu_zero;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_addr_sel = 1'b1;
                mem_we       = (bus.opcode == OP_SW);
                if (bus.mem_ready) begin
                    mem_req = 1'b1;
                    if (bus.opcode == OP_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_hit) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end else begin
                    mem_req = 1'b1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
                case (bus.opcode)
                    OP_LW:   wb_sel = 2'b01;
                    OP_LI:   wb_sel = 2'b10;
                    default: wb_sel = 2'b00;
                endcase
            end
            S_HALT:  halted = 1'b1;
            default: state_d = S_BOOT;
        endcase
    end

    // Wait counter restarts whenever the access completes or the state moves on.
    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) || bus.mem_ready) begin
            wait_d = 8'd0;
        end else if (mem_req) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_BOOT;
            wait_q      <= 8'd0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (timeout) begin
                bus_error_q <= 1'b1;
            end
        end
    end

    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr_sel = mem_addr_sel;
    assign bus.ir_write     = ir_write;
    assign bus.pc_write     = pc_write;
    assign bus.pc_src       = pc_src;
    assign bus.alu_src_b    = alu_src_b;
    assign bus.reg_write    = reg_write;
    assign bus.wb_sel       = wb_sel;
    assign bus.illegal_op   = illegal_op;
    assign bus.halted       = halted;
    assign bus.bus_error    = bus_error_q;

`ifdef MIPS_CTRL_PERF_EN
    logic [PERF_W-1:0] retired_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.instr_retired = retired_q;
`else
    logic unused_retire;
    assign unused_retire     = retire;
    assign bus.instr_retired = {PERF_W{1'b0}};
`endif
endmodule
